fragment_writer: RTL and testbench
==================================

// Module: fragment_writer
// PURPOSE
//  Sink end of the rasterizer fragment stream. Accepts covered-pixel fragments (valid-only, no backpressure),
//  clips to the screen, buffers them in a FIFO, converts (x,y) to a linear framebuffer address and writes
//  one colour word per fragment to framebuffer memory over a req/ack port. Reports triangle completion after drain.
// PARAMETERS
//  CORD_WIDTH   10   signed fragment coordinate width (matches rasterizer)
//  COLOR_WIDTH  16   pixel colour word width
//  FB_WIDTH     320  framebuffer width in pixels
//  FB_HEIGHT    240  framebuffer height in pixels
//  FIFO_DEPTH   8    fragment FIFO entries, power of 2, >=2
//  ADDR_WIDTH   $clog2(FB_WIDTH*FB_HEIGHT)  derived localparam, not overridable
// PORTS
//  clk               in   1            clock
//  rst               in   1            synchronous reset, active-high
//  i_start           in   1            one-cycle strobe, same cycle as rasterizer i_start
//  i_color           in   COLOR_WIDTH  flat triangle colour, latched on i_start
//  i_fragment_valid  in   1            fragment present this cycle
//  i_fragment_x      in   CORD_WIDTH   signed fragment x
//  i_fragment_y      in   CORD_WIDTH   signed fragment y
//  i_raster_done     in   1            rasterizer o_done (level, high when idle)
//  o_mem_req         out  1            write request
//  o_mem_addr        out  ADDR_WIDTH   y*FB_WIDTH + x
//  o_mem_wdata       out  COLOR_WIDTH  colour word
//  i_mem_ack         in   1            write accepted
//  o_busy            out  1            state != IDLE
//  o_done            out  1            one-cycle pulse: all fragments of triangle written
//  o_overflow        out  1            sticky: a fragment was dropped on full FIFO; cleared by i_start
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, colour 0; o_mem_req/o_busy/o_done/o_overflow=0, o_mem_addr/o_mem_wdata=0.
//  FSM IDLE->RUN on i_start (i_start outside IDLE ignored). RUN: seen_busy set when i_raster_done==0;
//   RUN->FLUSH when seen_busy && i_raster_done. FLUSH->DONE when FIFO empty && !o_mem_req.
//   DONE: o_done=1 for exactly that cycle, ->IDLE next.
//  Accept: fragment enqueued only in RUN/FLUSH with i_fragment_valid. Clip first: x<0, y<0, x>=FB_WIDTH,
//   y>=FB_HEIGHT -> discarded, not enqueued, not overflow. In IDLE/DONE fragments ignored.
//  Address y*FB_WIDTH+x computed at enqueue (unsigned, ADDR_WIDTH, exact after clip); entry = {addr}.
//  Full FIFO + in-range fragment: drop it, set o_overflow. Simultaneous pop+push on full: push accepted.
//  Mem port: head entry drives o_mem_addr, o_mem_wdata=latched colour. o_mem_req rises the cycle after the
//   entry is enqueued into an empty FIFO (1-cycle min latency); req/addr/data held stable until i_mem_ack.
//   Transfer on req&&ack; next entry presented on the following cycle with req kept high (back-to-back, 1/clk).
//  Reset mid-operation: everything returns to reset values; an un-acked req is abandoned.
// CONFIGURATION
//  FRAGMENT_WRITER_STATS_EN defined: adds outputs o_stat_written, o_stat_clipped, o_stat_dropped (each 16b,
//   saturating), cleared on i_start and rst, counting transfers, clip discards, overflow drops.
//  Not defined: ports absent, no counters; all other behaviour identical.
// STRUCTURE
//  gpu_pkg: fragment struct typedef (x,y), fragment_writer state enum (IDLE/RUN/FLUSH/DONE), clip helper fn.
//  One sub-module: frag_fifo (sync FIFO, parameterised width/depth, push/pop/full/empty, registered head).
// TESTING
//  Start, colour 16'hF800, fragments (0,0),(1,0),(0,1), ack tied 1 -> writes addr 0,1,320 data F800; o_done once.
//  Fragments (-1,5),(320,0),(5,240),(319,239) -> only addr 76799 written; overflow stays 0.
//  Ack held low 20 cycles, 10 in-range fragments, depth 8 -> first 8 written in order, o_overflow=1.
//  Ack toggling every other cycle -> addr/data stable while req&&!ack; no write duplicated or lost.
//  i_raster_done never goes low (degenerate tri) then high -> stays RUN until low/high seen; no spurious o_done.
//  rst asserted with 3 queued fragments -> next cycle o_mem_req=0, o_busy=0; fresh start behaves as test 1.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the fragment sink: fragment coordinates, writer FSM states
// and the screen clip test.
package gpu_pkg;

   localparam int FRAG_CORD_WIDTH = 10;

   typedef struct packed {
      logic signed [FRAG_CORD_WIDTH-1:0] x;
      logic signed [FRAG_CORD_WIDTH-1:0] y;
   } fragment_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } fw_state_t;

   // Coordinates arrive sign-extended so negative values clip correctly.
   function automatic logic on_screen(input int x, input int y, input int w, input int h);
      return (x >= 0) && (y >= 0) && (x < w) && (y < h);
   endfunction

endpackage

// File: rtl/fragment_writer_frag_fifo.sv
// Synchronous FIFO for framebuffer write addresses. The head is read from
// register storage addressed by a registered pointer.
module frag_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees a slot, so a push on full still lands.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fragment_writer.sv
// Rasterizer fragment sink: clips, buffers and writes flat-colour pixels to the
// framebuffer. Define FRAGMENT_WRITER_STATS_EN to add saturating statistics outputs.
module fragment_writer
   import gpu_pkg::*;
#(
   parameter int  CORD_WIDTH  = 10,
   parameter int  COLOR_WIDTH = 16,
   parameter int  FB_WIDTH    = 320,
   parameter int  FB_HEIGHT   = 240,
   parameter int  FIFO_DEPTH  = 8,
   localparam int ADDR_WIDTH  = $clog2(FB_WIDTH*FB_HEIGHT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [COLOR_WIDTH-1:0] i_color,
   input  logic                   i_fragment_valid,
   input  logic [CORD_WIDTH-1:0]  i_fragment_x,
   input  logic [CORD_WIDTH-1:0]  i_fragment_y,
   input  logic                   i_raster_done,
   output logic                   o_mem_req,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   output logic [COLOR_WIDTH-1:0] o_mem_wdata,
   input  logic                   i_mem_ack,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_overflow
`ifdef FRAGMENT_WRITER_STATS_EN
   ,
   output logic [15:0]            o_stat_written,
   output logic [15:0]            o_stat_clipped,
   output logic [15:0]            o_stat_dropped
`endif
);

   fw_state_t              state_reg;
   fw_state_t              state_next;
   logic                   seen_busy_reg;
   logic [COLOR_WIDTH-1:0] color_reg;
   logic                   overflow_reg;

   logic                   start_accept;
   logic                   accept;
   logic                   in_range;
   logic                   clip;
   logic                   push_req;
   logic                   drop;
   logic                   pop;
   logic [ADDR_WIDTH-1:0]  frag_addr;
   logic [ADDR_WIDTH-1:0]  fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;

   assign start_accept = (state_reg == IDLE) && i_start;
   assign accept       = ((state_reg == RUN) || (state_reg == FLUSH)) && i_fragment_valid;
   assign in_range     = on_screen(int'($signed(i_fragment_x)), int'($signed(i_fragment_y)),
                                   FB_WIDTH, FB_HEIGHT);
   assign clip         = accept && !in_range;
   assign push_req     = accept && in_range;
   assign pop          = o_mem_req && i_mem_ack;
   assign drop         = push_req && fifo_full && !pop;

   // Exact after clipping: the product never exceeds the framebuffer size.
   assign frag_addr = ADDR_WIDTH'(i_fragment_y) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(i_fragment_x);

   frag_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data (frag_addr),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign o_mem_req   = !fifo_empty;
   assign o_mem_addr  = o_mem_req ? fifo_head : '0;
   assign o_mem_wdata = o_mem_req ? color_reg : '0;
   assign o_overflow  = overflow_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      o_busy     = (state_reg != IDLE);
      o_done     = 1'b0;
      case (state_reg)
         IDLE:    if (i_start) state_next = RUN;
         RUN:     if (seen_busy_reg && i_raster_done) state_next = FLUSH;
         FLUSH:   if (fifo_empty && !o_mem_req) state_next = DONE;
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The rasterizer must be seen busy before its idle level means "finished".
   always_ff @(posedge clk) begin
      if (rst) begin
         seen_busy_reg <= 1'b0;
         color_reg     <= '0;
         overflow_reg  <= 1'b0;
      end else if (start_accept) begin
         seen_busy_reg <= 1'b0;
         color_reg     <= i_color;
         overflow_reg  <= 1'b0;
      end else begin
         if ((state_reg == RUN) && !i_raster_done) begin
            seen_busy_reg <= 1'b1;
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

`ifdef FRAGMENT_WRITER_STATS_EN
   logic [2:0] stat_inc;
   assign stat_inc = {drop, clip, pop};

   for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (rst || start_accept) begin
            cnt_reg <= '0;
         end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
            cnt_reg <= cnt_reg + 16'd1;
         end
      end
   end

   assign o_stat_written = g_stat[0].cnt_reg;
   assign o_stat_clipped = g_stat[1].cnt_reg;
   assign o_stat_dropped = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_fragment_writer.sv
// Scoreboard bench for fragment_writer: a driver with an occupancy-level
// reference model feeds expected writes to a decoupled memory-port monitor.
`timescale 1ns/1ps
module tb_fragment_writer;
   import gpu_pkg::*;

   localparam int CW    = 10;
   localparam int COLW  = 16;
   localparam int FBW   = 320;
   localparam int FBH   = 240;
   localparam int DEPTH = 8;
   localparam int AW    = 17;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_start;
   logic [COLW-1:0] i_color;
   logic            i_fragment_valid;
   logic [CW-1:0]   i_fragment_x;
   logic [CW-1:0]   i_fragment_y;
   logic            i_raster_done;
   logic            o_mem_req;
   logic [AW-1:0]   o_mem_addr;
   logic [COLW-1:0] o_mem_wdata;
   logic            i_mem_ack;
   logic            o_busy;
   logic            o_done;
   logic            o_overflow;
`ifdef FRAGMENT_WRITER_STATS_EN
   logic [15:0]     o_stat_written;
   logic [15:0]     o_stat_clipped;
   logic [15:0]     o_stat_dropped;
`endif

   always #5 clk = ~clk;

   fragment_writer dut (
      .clk              (clk),
      .rst              (rst),
      .i_start          (i_start),
      .i_color          (i_color),
      .i_fragment_valid (i_fragment_valid),
      .i_fragment_x     (i_fragment_x),
      .i_fragment_y     (i_fragment_y),
      .i_raster_done    (i_raster_done),
      .o_mem_req        (o_mem_req),
      .o_mem_addr       (o_mem_addr),
      .o_mem_wdata      (o_mem_wdata),
      .i_mem_ack        (i_mem_ack),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_overflow       (o_overflow)
`ifdef FRAGMENT_WRITER_STATS_EN
      ,
      .o_stat_written   (o_stat_written),
      .o_stat_clipped   (o_stat_clipped),
      .o_stat_dropped   (o_stat_dropped)
`endif
   );

   int            tests = 0;
   int            fails = 0;
   int            sb[$];
   int            m_count = 0;
   bit            active = 0;
   bit            exp_ovf = 0;
   logic [15:0]   exp_color = '0;
   int            done_cnt = 0;
   int            ack_mode = 0;
   int            tcyc = 0;
   bit            prev_hold = 0;
   logic [AW-1:0] prev_addr;
   logic [15:0]   prev_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: one line per memory transfer, compared against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 0;
      end else begin
         if (prev_hold) begin
            check("hold_req", o_mem_req, 1);
            check("hold_addr", o_mem_addr, prev_addr);
            check("hold_data", o_mem_wdata, prev_data);
         end
         if (o_mem_req && i_mem_ack) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr %0d expected no write", o_mem_addr);
            end else begin
               int exp_addr;
               exp_addr = sb.pop_front();
               $display("[TB] write addr=%0d data=%h (expect %0d/%h)", o_mem_addr, o_mem_wdata,
                        exp_addr, exp_color);
               check("wr_addr", o_mem_addr, exp_addr);
               check("wr_data", o_mem_wdata, exp_color);
            end
         end
         prev_hold = o_mem_req && !i_mem_ack;
         prev_addr = o_mem_addr;
         prev_data = o_mem_wdata;
         if (o_done) done_cnt++;
      end
   end

   function automatic bit ack_now();
      case (ack_mode)
         0:       return 1'b1;
         1:       return (tcyc >= 20);
         2:       return tcyc[0];
         3:       return 1'($urandom_range(0, 1));
         default: return 1'b0;
      endcase
   endfunction

   // One clock of stimulus; the model tracks FIFO occupancy and expected writes.
   task automatic step(input bit start, input bit valid, input int x, input int y, input bit rdone);
      bit ack;
      bit pop;
      bit inr;
      ack              = ack_now();
      i_start          = start;
      i_fragment_valid = valid;
      i_fragment_x     = CW'(x);
      i_fragment_y     = CW'(y);
      i_raster_done    = rdone;
      i_mem_ack        = ack;
      pop = (m_count > 0) && ack;
      inr = (x >= 0) && (y >= 0) && (x < FBW) && (y < FBH);
      @(posedge clk);
      if (pop) m_count--;
      if (active && valid && inr) begin
         if (m_count < DEPTH) begin
            m_count++;
            sb.push_back(y * FBW + x);
         end else begin
            exp_ovf = 1;
         end
      end
      if (start && !active) begin
         active    = 1;
         exp_ovf   = 0;
         exp_color = i_color;
      end
      tcyc++;
      #1;
      i_start          = 1'b0;
      i_fragment_valid = 1'b0;
   endtask

   task automatic run_tri(input logic [15:0] color, input int mode, input int fx[$], input int fy[$],
                          input int pre_idle, input bit gaps);
      int base;
      bit seen;
      base     = done_cnt;
      seen     = 0;
      ack_mode = mode;
      tcyc     = 0;
      i_color  = color;
      step(1, 0, 0, 0, 1);
      if (pre_idle > 0) begin
         repeat (pre_idle) step(0, 0, 0, 0, 1);
         check("degenerate_busy", o_busy, 1);
         check("degenerate_no_done", done_cnt - base, 0);
      end
      for (int i = 0; i < fx.size(); i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) step(0, 0, 0, 0, 0);
         step(0, 1, fx[i], fy[i], 0);
      end
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 400 && !seen; i++) begin
         step(0, 0, 0, 0, 1);
         if (o_done) seen = 1;
      end
      check("done_seen", seen, 1);
      active = 0;
      repeat (3) step(0, 1, 10, 10, 1);
      check("done_pulses", done_cnt - base, 1);
      check("pending_writes", sb.size(), 0);
      check("overflow", o_overflow, exp_ovf);
      check("busy_after", o_busy, 0);
      $display("[TB] triangle color=%h mode=%0d frags=%0d done", color, mode, fx.size());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int qx[$];
      int qy[$];
      rst = 1'b1;
      i_start = 0; i_color = '0; i_fragment_valid = 0; i_fragment_x = '0; i_fragment_y = '0;
      i_raster_done = 1'b1; i_mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", o_mem_req, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_overflow", o_overflow, 0);
      check("rst_addr", o_mem_addr, 0);
      check("rst_wdata", o_mem_wdata, 0);
      rst = 1'b0;
      step(0, 1, 7, 7, 1);

      qx = '{0, 1, 0};   qy = '{0, 0, 1};
      run_tri(16'hF800, 0, qx, qy, 0, 0);

      qx = '{-1, 320, 5, 319}; qy = '{5, 0, 240, 239};
      run_tri(16'h07E0, 0, qx, qy, 0, 0);

      qx = '{}; qy = '{};
      for (int i = 0; i < 10; i++) begin qx.push_back(i); qy.push_back(3); end
      run_tri(16'h001F, 1, qx, qy, 0, 0);

      qx = '{}; qy = '{};
      for (int i = 0; i < 6; i++) begin qx.push_back(100 + i); qy.push_back(50 + i); end
      run_tri(16'hABCD, 2, qx, qy, 0, 0);

      qx = '{2}; qy = '{2};
      run_tri(16'h5555, 0, qx, qy, 10, 0);

      // Reset with three queued fragments and an unacknowledged request.
      ack_mode = 4; tcyc = 0; i_color = 16'h1234;
      step(1, 0, 0, 0, 1);
      check("latency_pre_req", o_mem_req, 0);
      step(0, 1, 3, 3, 0);
      check("latency_req", o_mem_req, 1);
      check("latency_addr", o_mem_addr, 3 * FBW + 3);
      step(0, 1, 4, 3, 0);
      step(0, 1, 5, 3, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_req", o_mem_req, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_addr", o_mem_addr, 0);
      sb.delete(); m_count = 0; active = 0; exp_ovf = 0;
      rst = 1'b0;
      step(0, 0, 0, 0, 1);
      qx = '{0, 1, 0};   qy = '{0, 0, 1};
      run_tri(16'hF800, 0, qx, qy, 0, 0);

      for (int t = 0; t < 20; t++) begin
         int n;
         qx = '{}; qy = '{};
         n = int'($urandom_range(5, 25));
         for (int i = 0; i < n; i++) begin
            qx.push_back(int'($urandom_range(0, 327)) - 4);
            qy.push_back(int'($urandom_range(0, 247)) - 4);
         end
         run_tri(16'($urandom), int'($urandom_range(0, 3)), qx, qy, 0, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
